cmd_fetch_dispatcher: RTL and testbench
=======================================

// Module: cmd_fetch_dispatcher
// PURPOSE
//  Fetches a batch of 64-bit command descriptors from a staging queue in memory over an AXI4 read
//  master and streams them, in order, to the downstream command consumer via valid/ready.
//  Sits between the AXI-Lite control registers (start, num_reqs, 64-bit queue address) and the
//  command execution datapath. Pulses done/err back to the control block at end of batch.
// PARAMETERS
//  MAX_BURST   16  max beats per AXI read burst (power of 2, 1..256)
//  FIFO_DEPTH  32  internal descriptor FIFO entries (power of 2, >= MAX_BURST)
// PORTS
//  aclk            in   1   clock; all logic rising-edge
//  aresetn         in   1   asynchronous active-low reset
//  cfg_start       in   1   1-cycle pulse: begin batch (ignored while busy)
//  cfg_num_reqs    in   32  descriptors in batch, sampled on accepted cfg_start
//  cfg_queue_addr  in   64  staging queue base byte address, sampled on accepted cfg_start
//  busy            out  1   batch in progress
//  done            out  1   1-cycle pulse at batch completion
//  err             out  1   sticky: last batch saw RRESP!=OKAY; cleared on accepted cfg_start
//  m_axi_araddr    out  64  read address
//  m_axi_arlen     out  8   beats-1
//  m_axi_arsize    out  3   constant 3'b011 (8 bytes)
//  m_axi_arburst   out  2   constant 2'b01 (INCR)
//  m_axi_arvalid   out  1   / m_axi_arready in 1 : AR handshake
//  m_axi_rdata     in   64  read data
//  m_axi_rresp     in   2   read response
//  m_axi_rlast     in   1   last beat of burst
//  m_axi_rvalid    in   1   / m_axi_rready out 1 : R handshake
//  cmd_data        out  64  descriptor to consumer
//  cmd_valid       out  1   / cmd_ready in 1 : descriptor handshake
// BEHAVIOUR
//  Reset: all outputs 0 except arsize=3, arburst=1; FIFO empty; FSM IDLE; counters cleared.
//  Reset mid-batch aborts immediately; no further AR/R/cmd traffic until next cfg_start.
//  Start: cfg_start in IDLE latches num_reqs into remaining, queue_addr[63:3]<<3 (low 3 bits forced 0)
//   into next_addr, clears err, sets busy next cycle. num_reqs==0 -> done pulse 1 cycle later, no AXI.
//  FSM: IDLE -> CALC -> ADDR -> DATA -> (CALC | DRAIN) -> IDLE.
//   CALC: beats = min(MAX_BURST, remaining, (4096-next_addr[11:0])/8). Wait in CALC until
//    FIFO free slots (minus reserved) >= beats; then load arlen=beats-1, araddr=next_addr.
//   ADDR: arvalid=1, araddr/arlen stable until arready; then next_addr+=beats*8, remaining-=beats.
//   DATA: rready=1 (space guaranteed by credit check); each R beat pushed to FIFO. On rlast:
//    remaining>0 and !err -> CALC, else DRAIN. Exactly one outstanding burst at any time.
//   DRAIN: wait FIFO empty and last cmd handshake done; done=1 for 1 cycle, busy=0, -> IDLE.
//  Errors: any beat with rresp!=0 sets err; beat still delivered downstream; current burst
//   completes; no further bursts issued; batch ends via DRAIN with done pulse and err=1.
//  rlast mismatch tolerated: FSM counts beats; transition on rlast only.
//  FIFO: show-ahead; cmd_valid = !empty; cmd_data = head. Pop on cmd_valid&&cmd_ready.
//   Simultaneous push+pop on full/empty handled; order preserved; zero-bubble throughput.
//  Latency: first cmd_valid no earlier than 1 cycle after first R beat accepted.
//  cfg_start while busy: ignored, no effect on latched values.
//  Address wrap: next_addr wraps modulo 2^64; bursts never cross a 4KB boundary.
// TESTING
//  1 num_reqs=4, addr=0x44A1_0000, mem={0x10000,0x20000,0x30000,0x40000}, cmd_ready=1 -> one AR
//    len=3 @0x44A1_0000; cmd_data sequence 0x10000..0x40000; done pulse; err=0.
//  2 num_reqs=30, MAX_BURST=16 -> ARs len=15 @0x44A1_0000 then len=13 @0x44A1_0080; 30 cmds in order.
//  3 addr=0x44A1_0FF0, num_reqs=5 -> AR len=1 @0x..0FF0, then len=2 @0x44A1_1000; no 4KB crossing.
//  4 cmd_ready held 0 with num_reqs=64 -> at most FIFO_DEPTH beats fetched, rready never set
//    without space; release ready -> all 64 delivered, done once.
//  5 rresp=SLVERR on beat 2 of first burst, num_reqs=40 -> burst finishes, no further AR, 16 cmds
//    out, done pulse, err=1 until next start.
//  6 num_reqs=0 -> done 1 cycle after start, no arvalid; cfg_start during batch ignored;
//    aresetn low mid-DATA -> all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/cmd_fetch_dispatcher.sv
// Descriptor fetch engine: reads a batch of 64-bit command descriptors from a
// staging queue over an AXI4 read master (one burst outstanding at a time),
// buffers them in a show-ahead FIFO and streams them to the command consumer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no batch; waiting for cfg_start
// CALC   | size next burst; hold until the FIFO has room for all beats
// ADDR   | AR channel valid; araddr/arlen held until arready
// DATA   | accepting R beats into the FIFO until rlast
// DRAIN  | no more bursts; wait for the FIFO to empty, then pulse done
module cmd_fetch_dispatcher #(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cfg_start,
    input  logic [31:0] cfg_num_reqs,
    input  logic [63:0] cfg_queue_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [63:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [9:0]  MAX_BEATS = 10'(MAX_BURST);
    localparam logic [9:0]  DEPTH_W   = 10'(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]  state;
    logic [31:0] remaining;
    logic [63:0] next_addr;
    logic [9:0]  burst_beats;

    logic [63:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fifo_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        beat_err;

    logic [9:0]  page_beats;
    logic [9:0]  calc_beats;
    logic [9:0]  free_slots;
    logic        credit_ok;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_C);

    assign busy          = (state != S_IDLE);
    assign m_axi_arvalid = (state == S_ADDR);
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b01;
    // Full-gating is only a backstop against a slave that overruns arlen;
    // the credit check in CALC normally keeps rready high through DATA.
    assign m_axi_rready  = (state == S_DATA) && !fifo_full;

    assign cmd_valid = !fifo_empty;
    assign cmd_data  = fifo_empty ? 64'd0 : fifo_mem[rd_ptr[AW-1:0]];

    assign push     = m_axi_rvalid && m_axi_rready;
    assign pop      = cmd_valid && cmd_ready;
    assign beat_err = push && (m_axi_rresp != 2'b00);

    // Next burst size: limited by MAX_BURST, descriptors left, and the 4KB page.
    always_comb begin
        page_beats = 10'd512 - {1'b0, next_addr[11:3]};
        calc_beats = MAX_BEATS;
        if (page_beats < calc_beats) begin
            calc_beats = page_beats;
        end
        if (remaining < {22'd0, calc_beats}) begin
            calc_beats = remaining[9:0];
        end
    end

    // Only one burst is ever outstanding, so nothing is reserved while in CALC.
    always_comb begin
        free_slots = DEPTH_W - 10'(fifo_count);
        credit_ok  = (free_slots >= calc_beats);
    end

    // Batch sequencing FSM, address/count bookkeeping, done/err flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= S_IDLE;
            remaining    <= '0;
            next_addr    <= '0;
            burst_beats  <= '0;
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (beat_err) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        remaining <= cfg_num_reqs;
                        next_addr <= cfg_queue_addr & ~64'h7;
                        err       <= 1'b0;
                        if (cfg_num_reqs == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (credit_ok) begin
                        burst_beats  <= calc_beats;
                        m_axi_araddr <= next_addr;
                        m_axi_arlen  <= 8'(calc_beats - 10'd1);
                        state        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        next_addr <= next_addr + {51'd0, burst_beats, 3'b000};
                        remaining <= remaining - {22'd0, burst_beats};
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    // rlast alone ends the burst; an error on this very beat counts.
                    if (push && m_axi_rlast) begin
                        if ((remaining != 32'd0) && !err && !beat_err) begin
                            state <= S_CALC;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers; extra MSB distinguishes full from empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are don't-care while empty (cmd_data is masked).
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= m_axi_rdata;
        end
    end

endmodule

// File: tb/tb_cmd_fetch_dispatcher.sv
module tb_cmd_fetch_dispatcher;

    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cfg_start;
    logic [31:0] cfg_num_reqs;
    logic [63:0] cfg_queue_addr;
    logic        busy, done, err;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [63:0] cmd_data;
    logic        cmd_valid, cmd_ready;

    always #5 aclk = ~aclk;

    cmd_fetch_dispatcher #(.MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_start(cfg_start), .cfg_num_reqs(cfg_num_reqs), .cfg_queue_addr(cfg_queue_addr),
        .busy(busy), .done(done), .err(err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
    );

    int errors = 0;
    int checks = 0;

    // expected traffic for the current batch
    logic [63:0] exp_ar_addr [$];
    int          exp_ar_beats [$];
    logic [63:0] exp_cmd [$];
    bit          exp_err;

    // memory/slave model state
    logic [63:0] batch_base;
    logic [63:0] salt;
    int          err_beat = -1;
    int          beat_no;
    int          ready_mode = 0;
    int          cyc;
    bit          sl_active = 0;
    bit          r_taken = 0;
    logic [63:0] sl_addr;
    int          sl_left;
    int          ar_seen, cmd_seen, done_seen, occ;

    bit          start_req = 0;
    logic [31:0] start_num;
    logic [63:0] start_addr;

    typedef struct {
        logic [63:0] base;
        int          n;
        int          eb;
        int          rmode;
        bit          poke;
        int          exp_ars;
        int          exp_cmds;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] data_of(input logic [63:0] addr);
        logic [63:0] idx;
        idx = (addr - batch_base) >> 3;
        return salt ^ ((idx + 64'd1) << 16);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: condition violated at cycle %0d", name, cyc);
        end
    endtask

    // Model of the batch: bursts split by MAX_BURST, remaining count and 4KB pages;
    // the burst holding an erroneous beat is the last one issued.
    task automatic build_model(input logic [63:0] base, input int n, input int eb, input logic [63:0] sl);
        logic [63:0] addr;
        int rem, b, g, pg;
        bit stop;
        exp_ar_addr.delete();
        exp_ar_beats.delete();
        exp_cmd.delete();
        batch_base = base;
        salt = sl;
        err_beat = eb;
        addr = base;
        rem = n;
        g = 0;
        exp_err = 0;
        while (rem > 0) begin
            pg = int'(addr[11:0]);
            b = MAX_BURST;
            if (rem < b) b = rem;
            if ((4096 - pg) / 8 < b) b = (4096 - pg) / 8;
            exp_ar_addr.push_back(addr);
            exp_ar_beats.push_back(b);
            for (int j = 0; j < b; j++) exp_cmd.push_back(data_of(addr + 64'(8 * j)));
            stop = (eb >= g) && (eb < g + b);
            g += b;
            addr += 64'(8 * b);
            rem -= b;
            if (stop) begin
                exp_err = 1;
                break;
            end
        end
        ar_seen = 0; cmd_seen = 0; done_seen = 0; occ = 0; beat_no = 0; cyc = 0;
    endtask

    // One clock: drive inputs at negedge, then predict/score the handshakes
    // that the next rising edge will complete.
    task automatic tick();
        int occ0;
        @(negedge aclk);
        cyc++;
        cfg_start = start_req;
        if (start_req) begin
            cfg_num_reqs   = start_num;
            cfg_queue_addr = start_addr;
        end
        start_req = 0;
        m_axi_arready = ($urandom_range(0, 3) != 0);
        if (!sl_active) m_axi_rvalid = 1'b0;
        else if (r_taken || !m_axi_rvalid) m_axi_rvalid = ($urandom_range(0, 3) != 0);
        r_taken = 0;
        m_axi_rdata = m_axi_rvalid ? data_of(sl_addr) : 64'hDEAD_BEEF_0BAD_F00D;
        m_axi_rlast = m_axi_rvalid && (sl_left == 1);
        m_axi_rresp = (m_axi_rvalid && beat_no == err_beat) ? 2'b10 : 2'b00;
        case (ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = (cyc > 200);
        endcase
        #1;
        occ0 = occ;
        if (done) done_seen++;
        if (cmd_valid && cmd_ready) begin
            cmd_seen++;
            check_true("cmd_before_beat", occ0 > 0);
            if (exp_cmd.size() == 0) check_true("unexpected_cmd", 1'b0);
            else check64("cmd_data", cmd_data, exp_cmd.pop_front());
            occ--;
        end
        if (m_axi_rready) check_true("rready_without_space", occ0 < FIFO_DEPTH);
        if (m_axi_rvalid && m_axi_rready) begin
            occ++;
            beat_no++;
            sl_addr += 64'd8;
            sl_left--;
            r_taken = 1;
            if (sl_left == 0) sl_active = 0;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_seen++;
            check_true("ar_while_burst_open", !sl_active);
            if (exp_ar_addr.size() == 0) check_true("unexpected_ar", 1'b0);
            else begin
                check64("araddr", m_axi_araddr, exp_ar_addr.pop_front());
                check64("arlen", 64'(m_axi_arlen), 64'(exp_ar_beats.pop_front() - 1));
            end
            check64("arsize", 64'(m_axi_arsize), 64'd3);
            check64("arburst", 64'(m_axi_arburst), 64'd1);
            sl_active = 1;
            sl_addr = m_axi_araddr;
            sl_left = int'(m_axi_arlen) + 1;
        end
    endtask

    task automatic run_batch(input logic [63:0] base, input int n, input int eb,
                             input int rmode, input bit poke, input logic [63:0] sl);
        int n_ars, n_cmds;
        bit poked;
        build_model(base, n, eb, sl);
        ready_mode = rmode;
        n_ars = exp_ar_addr.size();
        n_cmds = exp_cmd.size();
        start_num = n;
        start_addr = base | 64'($urandom_range(0, 7));
        start_req = 1;
        tick();
        poked = 0;
        while (done_seen == 0 && cyc < 4000) begin
            if (poke && !poked && busy && ar_seen < n_ars) begin
                start_num = 7;
                start_addr = base + 64'h10_0000;
                start_req = 1;
                poked = 1;
            end
            tick();
        end
        if (done_seen == 0) check_true("batch_timeout", 1'b0);
        repeat (4) tick();
        check64("done_count", 64'(done_seen), 64'd1);
        check64("ar_count", 64'(ar_seen), 64'(n_ars));
        check64("cmd_count", 64'(cmd_seen), 64'(n_cmds));
        check64("err_flag", 64'(err), 64'(exp_err));
        check64("busy_after", 64'(busy), 64'd0);
        check64("fifo_empty_after", 64'(cmd_valid), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_done", 64'(done), 64'd0);
        check64("rst_err", 64'(err), 64'd0);
        check64("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check64("rst_araddr", m_axi_araddr, 64'd0);
        check64("rst_arlen", 64'(m_axi_arlen), 64'd0);
        check64("rst_arsize", 64'(m_axi_arsize), 64'd3);
        check64("rst_arburst", 64'(m_axi_arburst), 64'd1);
        check64("rst_rready", 64'(m_axi_rready), 64'd0);
        check64("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check64("rst_cmd_data", cmd_data, 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rbase;
        int rn, reb, guard;

        vecs[0] = '{64'h44A1_0000, 4, -1, 0, 0, 1, 4, 0};
        vecs[1] = '{64'h44A1_0000, 30, -1, 0, 1, 2, 30, 0};
        vecs[2] = '{64'h44A1_0FF0, 5, -1, 1, 0, 2, 5, 0};
        vecs[3] = '{64'h44A1_0000, 64, -1, 2, 1, 4, 64, 0};
        vecs[4] = '{64'h44A1_0000, 40, 1, 1, 0, 1, 16, 1};
        vecs[5] = '{64'h44A1_0000, 0, -1, 0, 0, 0, 0, 0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFE0, 10, -1, 1, 0, 2, 10, 0};
        vecs[7] = '{64'h1000_0F80, 40, 20, 1, 1, 2, 32, 1};

        aresetn = 1'b0;
        cfg_start = 1'b0;
        cfg_num_reqs = '0;
        cfg_queue_addr = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rdata = '0;
        m_axi_rresp = '0;
        m_axi_rlast = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check_reset_outputs();
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_batch(vecs[i].base, vecs[i].n, vecs[i].eb, vecs[i].rmode, vecs[i].poke, 64'd0);
            check64($sformatf("vec%0d_ars", i), 64'(ar_seen), 64'(vecs[i].exp_ars));
            check64($sformatf("vec%0d_cmds", i), 64'(cmd_seen), 64'(vecs[i].exp_cmds));
            check64($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
        end

        // zero-length batch: done exactly one cycle after the start edge
        build_model(64'h1234_5678, 0, -1, 64'd0);
        ready_mode = 0;
        start_num = 0;
        start_addr = 64'h1234_5678;
        start_req = 1;
        tick();
        check64("zero_done_early", 64'(done), 64'd0);
        tick();
        check64("zero_done_pulse", 64'(done), 64'd1);
        check64("zero_busy", 64'(busy), 64'd0);
        tick();
        check64("zero_done_clear", 64'(done), 64'd0);
        check64("zero_no_ar", 64'(ar_seen), 64'd0);

        // reset in the middle of a data phase
        build_model(64'h2000_0000, 64, -1, 64'hA5A5_0000_0000_0000);
        ready_mode = 2;
        start_num = 64;
        start_addr = 64'h2000_0000;
        start_req = 1;
        tick();
        guard = 0;
        while (!(occ >= 8 && sl_active) && guard < 500) begin
            tick();
            guard++;
        end
        check_true("mid_data_reached", occ >= 8 && sl_active);
        @(negedge aclk);
        aresetn = 1'b0;
        sl_active = 0;
        m_axi_rvalid = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        exp_ar_addr.delete();
        exp_ar_beats.delete();
        exp_cmd.delete();
        ready_mode = 0;
        ar_seen = 0; cmd_seen = 0; done_seen = 0; occ = 0;
        repeat (30) tick();
        check64("post_reset_ar", 64'(ar_seen), 64'd0);
        check64("post_reset_cmd", 64'(cmd_seen), 64'd0);
        check64("post_reset_done", 64'(done_seen), 64'd0);
        check64("post_reset_busy", 64'(busy), 64'd0);

        // randomized batches against the model
        for (int k = 0; k < 30; k++) begin
            rbase = {$urandom, $urandom} & ~64'h7;
            if ($urandom_range(0, 1) == 1) rbase[11:0] = 12'(4096 - 8 * $urandom_range(1, 20));
            rn = int'($urandom_range(0, 50));
            reb = -1;
            if (rn > 0 && $urandom_range(0, 3) == 0) reb = int'($urandom_range(0, rn - 1));
            run_batch(rbase, rn, reb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
